// File: rtl/bidir_piso_tx.sv
// Parallel-in, serial-out transmitter with per-frame LSB/MSB-first select and registered outputs.
// Define BIDIR_PISO_PARITY_EN to append an even-parity bit to every frame.
module bidir_piso_tx #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    input  logic             rl_mode,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef BIDIR_PISO_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
    typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             sout_d, sout_valid_d, sout_last_d;
    logic             load_ready_d, busy_d;
    logic [WIDTH-1:0] shifted;
    logic             last_bit;
`ifdef BIDIR_PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    // Next word position: the bit to emit next always sits at the exit end of shreg.
    assign shifted  = dir_q ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (load_valid) state_d = StShift;
            end
            StShift: begin
`ifdef BIDIR_PISO_PARITY_EN
                if (last_bit) state_d = StParity;
`else
                if (last_bit) state_d = StIdle;
`endif
            end
`ifdef BIDIR_PISO_PARITY_EN
            StParity: state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        sout_last_d  = 1'b0;
`ifdef BIDIR_PISO_PARITY_EN
        parity_d     = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (load_valid) begin
                    shreg_d      = din;
                    dir_d        = rl_mode;
                    cnt_d        = '0;
                    sout_d       = rl_mode ? din[WIDTH-1] : din[0];
                    sout_valid_d = 1'b1;
`ifdef BIDIR_PISO_PARITY_EN
                    parity_d     = ^din;
`endif
                end
            end
            StShift: begin
                if (last_bit) begin
`ifdef BIDIR_PISO_PARITY_EN
                    sout_d       = parity_q;
                    sout_valid_d = 1'b1;
                    sout_last_d  = 1'b1;
`endif
                end else begin
                    cnt_d        = cnt_q + CW'(1);
                    shreg_d      = shifted;
                    sout_d       = dir_q ? shifted[WIDTH-1] : shifted[0];
                    sout_valid_d = 1'b1;
`ifndef BIDIR_PISO_PARITY_EN
                    sout_last_d  = (cnt_q == CW'(WIDTH - 2));
`endif
                end
            end
            default: ;
        endcase
        load_ready_d = (state_d == StIdle);
        busy_d       = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q    <= '0;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
            load_ready <= 1'b1;
            busy       <= 1'b0;
`ifdef BIDIR_PISO_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            sout       <= sout_d;
            sout_valid <= sout_valid_d;
            sout_last  <= sout_last_d;
            load_ready <= load_ready_d;
            busy       <= busy_d;
`ifdef BIDIR_PISO_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: doc/bidir_piso_tx.md
Name: bidir_piso_tx

Overview:
- Parallel-in, serial-out transmitter that produces the serial bit stream consumed by the team's 4-bit bidirectional shift register.
- Accepts a parallel word through a valid/ready load handshake.
- Serializes the word LSB-first or MSB-first, chosen by a direction select captured at load.
- Flags every valid bit and marks the last bit of each frame.

Parameters:
- WIDTH, 4, data word width in bits (legal values 2 to 32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- din  input  WIDTH  parallel word to transmit
- load_valid  input  1  din/rl_mode valid; a load occurs when load_valid and load_ready are both high on a clk edge
- rl_mode  input  1  0 = LSB first (feeds right-shift receiver), 1 = MSB first (feeds left-shift receiver); sampled only at load
- load_ready  output  1  high only in IDLE
- sout  output  1  serial data bit
- sout_valid  output  1  sout carries a frame bit this cycle
- sout_last  output  1  high with the final bit of the frame
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, load_ready=1, sout=0, sout_valid=0, sout_last=0, busy=0, internal shift register=0, bit counter=0.
- Reset mid-frame: rst asserted at any time aborts the frame immediately, without waiting for a clock edge. No partial-frame bits follow.
- All outputs are registered; no combinational path from inputs to outputs.
- IDLE state:
  - load_ready=1, sout_valid=0, sout=0.
  - On the clk edge where load_valid=1, the block captures din into the shift register and rl_mode into a direction flag, clears the counter, and enters SHIFT.
- SHIFT state (latency 1 cycle from the load edge to the first bit):
  - sout_valid=1 for exactly WIDTH consecutive cycles.
  - Direction flag 0: sout = din[0], din[1], … din[WIDTH-1].
  - Direction flag 1: sout = din[WIDTH-1], … din[0].
  - The counter increments each cycle, WIDTH-1 downto... wrap-free: it counts 0 to WIDTH-1 and never wraps inside a frame.
  - sout_last=1 only when the counter equals WIDTH-1 (PARITY_EN off).
  - After the last bit, the next state is IDLE. sout_valid and sout_last drop to 0 and load_ready rises in the same cycle.
- Minimum frame spacing: one idle cycle between frames. The earliest next load edge is the first IDLE cycle, and the next frame's first bit appears one cycle after that edge.
- Inputs ignored while busy:
  - load_valid while busy is ignored; no queuing and no error.
  - Changes on din or rl_mode during a frame do not affect it.
- Simultaneous rst and load_valid: rst wins and no load occurs.
- X on din with load_valid=0 must not propagate to sout.

Optional Feature:
- Macro: BIDIR_PISO_PARITY_EN.
- When defined:
  - After the WIDTH data bits, a PARITY state emits one extra bit with sout_valid=1.
  - That bit is the even-parity bit: XOR of all captured data bits.
  - sout_last moves to the parity bit; the frame is WIDTH+1 cycles, then IDLE.
  - Parity is computed from the word captured at load, not from live din.
- When undefined:
  - No PARITY state and no parity logic.
  - The frame is exactly WIDTH bits, with sout_last on data bit WIDTH-1.

Test Plan:
- WIDTH=4, din=4'b1011, rl_mode=0, one-cycle load_valid pulse: sout = 1,1,0,1 on the 4 cycles after the load edge. sout_valid=1 for all 4 cycles, sout_last=1 only on the 4th. load_ready returns to 1 on the 5th cycle.
- din=4'b1011, rl_mode=1: sout = 1,0,1,1. rl_mode toggled and din set to 4'b0000 mid-frame: sequence unchanged.
- load_valid held high continuously with din=4'b0110 then 4'b1001: frames are separated by exactly one idle cycle with sout_valid=0. Second frame LSB-first = 1,0,0,1. Any load_valid during busy is ignored.
- rst asserted asynchronously between clock edges during bit 2: all outputs take reset values immediately. After release, the next load transmits normally.
- BIDIR_PISO_PARITY_EN defined, din=4'b1011, rl_mode=0: sout = 1,1,0,1,1 (parity=1). sout_last is on the 5th bit. din=4'b0011 gives parity bit 0.
- Receiver loopback: sout drives ri of the shift register with its rl_mode driven from the same rl_mode. After the 4 valid bits, the register holds the transmitted word, and qbar equals its complement.
